counter_bank_dev_io: RTL and testbench

- Parametrised multi-channel timer/counter peripheral for the MIO bus; successor to the fixed three-channel counter.
- Provides NUM_CH independent WIDTH-bit channels, each with its own tick source, four counting modes, a per-channel output and a sticky done flag.
- The flags are combined into a single maskable interrupt line feeding the CPU INT input.
- The CPU reaches every channel through a flat register window decoded by the bus.

---
 rtl/counter_bank_dev_io.sv | 115 +++++++++++
 tb/tb_counter_bank_dev_io.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bank_dev_io.sv
// counter_bank_dev_io: NUM_CH-channel timer/counter bank with a flat register window,
// four counting modes per channel and one registered, maskable interrupt.
module counter_bank_dev_io #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int CH_AW  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_tick_in,
    input  logic              i_bus_we,
    input  logic [CH_AW+1:0]  i_bus_addr,
    input  logic [31:0]       i_bus_wdata,
    output logic [31:0]       o_bus_rdata,
    output logic [NUM_CH-1:0] o_ch_out,
    output logic              o_irq
);
    localparam logic [1:0] REG_LOAD = 2'd0, REG_CTRL = 2'd1, REG_COUNT = 2'd2;
    typedef enum logic [1:0] {M_ONESHOT, M_PERIODIC, M_SQUARE, M_FREERUN} mode_e;
    logic [CH_AW-1:0]  w_ch;
    logic [1:0]        w_reg;
    logic [31:0]       w_rd [NUM_CH];
    logic [NUM_CH-1:0] w_flag;
    logic              r_irq;
    logic              w_unused;
    assign w_ch     = i_bus_addr[CH_AW+1:2];
    assign w_reg    = i_bus_addr[1:0];
    assign w_unused = ^i_bus_wdata;
    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [WIDTH-1:0] r_load, r_count;
            logic             r_en, r_irq_en, r_done, r_out;
            mode_e            r_mode;
            logic [2:0]       r_sync;
            logic             w_sel, w_wr_load, w_wr_ctrl, w_w1c;
            logic             w_tick, w_last, w_expire;
            mode_e            w_new_mode;
            assign w_sel      = (w_ch == CH_AW'(c));
            assign w_wr_load  = i_bus_we & w_sel & (w_reg == REG_LOAD);
            assign w_wr_ctrl  = i_bus_we & w_sel & (w_reg == REG_CTRL);
            assign w_w1c      = i_bus_we & w_sel & (&w_reg) & i_bus_wdata[0];
            assign w_new_mode = mode_e'(i_bus_wdata[2:1]);
            // LOAD/CTRL writes take priority, so a coincident tick is dropped
            assign w_tick     = r_sync[1] & ~r_sync[2] & r_en & ~w_wr_load & ~w_wr_ctrl;
            assign w_last     = r_count <= WIDTH'(1);
            assign w_expire   = w_tick & ((r_mode == M_FREERUN) ? (&r_count) : w_last);
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_load   <= '0;
                    r_count  <= '0;
                    r_en     <= 1'b0;
                    r_irq_en <= 1'b0;
                    r_done   <= 1'b0;
                    r_out    <= 1'b0;
                    r_mode   <= M_ONESHOT;
                    r_sync   <= '0;
                end else begin
                    r_sync <= {r_sync[1:0], i_tick_in[c]};
                    if (w_expire)
                        r_done <= 1'b1;
                    else if (w_w1c)
                        r_done <= 1'b0;
                    if (r_mode == M_PERIODIC)
                        r_out <= 1'b0;
                    if (w_wr_load) begin
                        r_load <= i_bus_wdata[WIDTH-1:0];
                        if (r_mode != M_FREERUN)
                            r_count <= i_bus_wdata[WIDTH-1:0];
                    end else if (w_wr_ctrl) begin
                        r_en     <= i_bus_wdata[0];
                        r_mode   <= w_new_mode;
                        r_irq_en <= i_bus_wdata[3];
                        if (!r_en && i_bus_wdata[0]) begin
                            r_count <= (w_new_mode == M_FREERUN) ? '0 : r_load;
                            r_out   <= 1'b0;
                        end
                    end else if (w_tick) begin
                        case (r_mode)
                            M_ONESHOT: begin
                                r_count <= w_last ? '0 : r_count - WIDTH'(1);
                                if (w_last)
                                    r_en <= 1'b0;
                            end
                            M_FREERUN: r_count <= r_count + WIDTH'(1);
                            default: begin
                                r_count <= w_last ? r_load : r_count - WIDTH'(1);
                                if (w_last)
                                    r_out <= (r_mode == M_PERIODIC) | ~r_out;
                            end
                        endcase
                    end
                end
            end
            assign o_ch_out[c] = (r_mode == M_ONESHOT) ? r_en :
                                 (r_mode == M_FREERUN) ? r_count[WIDTH-1] : r_out;
            assign w_flag[c]   = r_done & r_irq_en;
            assign w_rd[c]     = (w_reg == REG_LOAD)  ? 32'(r_load) :
                                 (w_reg == REG_CTRL)  ? {28'b0, r_irq_en, r_mode, r_en} :
                                 (w_reg == REG_COUNT) ? 32'(r_count) : {31'b0, r_done};
        end
    endgenerate
    always_comb begin
        o_bus_rdata = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (w_ch == CH_AW'(k))
                o_bus_rdata = w_rd[k];
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_irq <= 1'b0;
        else
            r_irq <= |w_flag;
    end
    assign o_irq = r_irq;
endmodule

// File: tb/tb_counter_bank_dev_io.sv
// tb_counter_bank_dev_io: directed vectors for counter_bank_dev_io, configured with
// WIDTH=8 and CH_AW=3 so the wrap and out-of-range channels are reachable.
module tb_counter_bank_dev_io;
    localparam int OP_W = 0, OP_R = 1, OP_T = 2, OP_Q = 3;
    localparam int LOAD = 0, CTRL = 1, COUNT = 2, STATUS = 3;
    typedef struct {
        int    op;
        int    ch;
        int    rg;
        int    data;
        int    exp;
        string nm;
    } vec_t;
    logic        clk, rst_n, we, irq;
    logic [3:0]  tick_in, ch_out;
    logic [4:0]  addr;
    logic [31:0] wdata, rdata, v;
    int          n_cmp, n_err, pulses;
    vec_t        tbl[$];
    counter_bank_dev_io #(.NUM_CH(4), .WIDTH(8), .CH_AW(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick_in(tick_in), .i_bus_we(we),
        .i_bus_addr(addr), .i_bus_wdata(wdata), .o_bus_rdata(rdata),
        .o_ch_out(ch_out), .o_irq(irq)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask
    task automatic wr(input int ch, input int rg, input int data);
        addr  = 5'((ch << 2) | rg);
        wdata = data;
        we    = 1'b1;
        step();
        we = 1'b0;
        step();
    endtask
    task automatic rd(input int ch, input int rg, output logic [31:0] val);
        addr = 5'((ch << 2) | rg);
        #1;
        val = rdata;
    endtask
    task automatic tick(input int ch);
        tick_in[ch] = 1'b1;
        repeat (3) step();
        tick_in[ch] = 1'b0;
        repeat (3) step();
    endtask
    function automatic void add(int op, int ch, int rg, int data, int exp, string nm);
        vec_t e;
        e.op = op; e.ch = ch; e.rg = rg; e.data = data; e.exp = exp; e.nm = nm;
        tbl.push_back(e);
    endfunction
    initial begin
        n_cmp = 0; n_err = 0;
        add(OP_R, 0, LOAD,   0, 0, "rst_load0");
        add(OP_R, 0, CTRL,   0, 0, "rst_ctrl0");
        add(OP_R, 2, COUNT,  0, 0, "rst_count2");
        add(OP_R, 3, STATUS, 0, 0, "rst_status3");
        add(OP_Q, 0, 0,      0, 0, "rst_irq");
        add(OP_T, 1, 0,      0, 0, "rst_chout1");
        add(OP_W, 0, LOAD,   5, 0, "");
        add(OP_R, 0, COUNT,  0, 5, "os_load_count");
        add(OP_W, 0, CTRL,   9, 0, "");
        add(OP_R, 0, CTRL,   0, 9, "os_ctrl");
        add(OP_T, 0, 0,      1, 1, "os_chout_t1");
        add(OP_R, 0, COUNT,  0, 4, "os_count_t1");
        add(OP_T, 0, 0,      1, 1, "os_chout_t2");
        add(OP_R, 0, COUNT,  0, 3, "os_count_t2");
        add(OP_T, 0, 0,      2, 1, "os_chout_t4");
        add(OP_R, 0, COUNT,  0, 1, "os_count_t4");
        add(OP_Q, 0, 0,      0, 0, "os_irq_t4");
        add(OP_T, 0, 0,      1, 0, "os_chout_t5");
        add(OP_R, 0, COUNT,  0, 0, "os_count_t5");
        add(OP_R, 0, STATUS, 0, 1, "os_done");
        add(OP_R, 0, CTRL,   0, 8, "os_en_cleared");
        add(OP_Q, 0, 0,      0, 1, "os_irq");
        add(OP_W, 0, STATUS, 0, 0, "");
        add(OP_R, 0, STATUS, 0, 1, "w0_no_clear");
        add(OP_W, 0, STATUS, 1, 0, "");
        add(OP_R, 0, STATUS, 0, 0, "w1c_done");
        add(OP_Q, 0, 0,      0, 0, "w1c_irq");
        add(OP_W, 5, LOAD,   8'h55, 0, "");
        add(OP_R, 5, LOAD,   0, 0, "oor_load5");
        add(OP_R, 1, LOAD,   0, 0, "oor_alias1");
        add(OP_W, 4, CTRL,   1, 0, "");
        add(OP_R, 4, CTRL,   0, 0, "oor_ctrl4");
        add(OP_R, 0, CTRL,   0, 8, "oor_alias0");
        add(OP_R, 0, COUNT,  0, 0, "oor_count0");
        add(OP_W, 2, LOAD,   2, 0, "");
        add(OP_W, 2, CTRL,   5, 0, "");
        add(OP_T, 2, 0,      0, 0, "sq_t0");
        add(OP_T, 2, 0,      1, 0, "sq_t1");
        add(OP_T, 2, 0,      1, 1, "sq_t2");
        add(OP_T, 2, 0,      1, 1, "sq_t3");
        add(OP_T, 2, 0,      1, 0, "sq_t4");
        add(OP_T, 2, 0,      1, 0, "sq_t5");
        add(OP_T, 2, 0,      1, 1, "sq_t6");
        add(OP_T, 2, 0,      1, 1, "sq_t7");
        add(OP_T, 2, 0,      1, 0, "sq_t8");
        add(OP_R, 2, COUNT,  0, 2, "sq_reload");
        add(OP_R, 2, STATUS, 0, 1, "sq_done");
        rst_n = 1'b0; we = 1'b0; tick_in = '0; addr = '0; wdata = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                OP_W: wr(tbl[i].ch, tbl[i].rg, tbl[i].data);
                OP_R: begin
                    rd(tbl[i].ch, tbl[i].rg, v);
                    chk(tbl[i].nm, v, tbl[i].exp);
                end
                OP_T: begin
                    repeat (tbl[i].data) tick(tbl[i].ch);
                    chk(tbl[i].nm, 32'(ch_out[tbl[i].ch]), tbl[i].exp);
                end
                default: chk(tbl[i].nm, 32'(irq), tbl[i].exp);
            endcase
        end
        // periodic: one-clock pulse and reload on every third tick
        wr(1, LOAD, 3);
        wr(1, CTRL, 3);
        pulses = 0;
        for (int k = 1; k <= 9; k++) begin
            tick_in[1] = 1'b1;
            repeat (3) step();
            if (ch_out[1]) pulses++;
            chk("per_chout", 32'(ch_out[1]), 32'(k % 3 == 0));
            rd(1, COUNT, v);
            chk("per_count", v, (k % 3 == 0) ? 3 : 3 - k % 3);
            step();
            chk("per_pulse_end", 32'(ch_out[1]), 0);
            tick_in[1] = 1'b0;
            repeat (3) step();
        end
        chk("per_pulses", pulses, 3);
        rd(1, STATUS, v);
        chk("per_done", v, 1);
        // free-run wrap over the full 8-bit range
        wr(3, CTRL, 7);
        for (int k = 1; k <= 256; k++) begin
            tick(3);
            rd(3, COUNT, v);
            chk("fr_count", v, k % 256);
            chk("fr_chout", 32'(ch_out[3]), 32'((k % 256) >= 128));
            if (k >= 255) begin
                rd(3, STATUS, v);
                chk("fr_done", v, 32'(k == 256));
            end
        end
        // LOAD write colliding with a tick event: write wins
        tick_in[1] = 1'b1;
        step(); step();
        addr = 5'((1 << 2) | LOAD); wdata = 7; we = 1'b1;
        step();
        we = 1'b0;
        rd(1, COUNT, v);
        chk("col_load", v, 7);
        tick_in[1] = 1'b0;
        repeat (3) step();
        tick(1);
        rd(1, COUNT, v);
        chk("col_after", v, 6);
        // expiry coinciding with W1C: done stays set
        wr(1, STATUS, 1);
        rd(1, STATUS, v);
        chk("col_pre_clear", v, 0);
        wr(1, LOAD, 1);
        tick_in[1] = 1'b1;
        step(); step();
        addr = 5'((1 << 2) | STATUS); wdata = 1; we = 1'b1;
        step();
        we = 1'b0;
        rd(1, STATUS, v);
        chk("col_w1c_done", v, 1);
        rd(1, COUNT, v);
        chk("col_w1c_reload", v, 1);
        tick_in[1] = 1'b0;
        repeat (3) step();
        // reset in the middle of a count
        wr(2, CTRL, 13);
        chk("mid_irq_on", 32'(irq), 1);
        wr(0, LOAD, 200);
        wr(0, CTRL, 9);
        tick(0);
        rd(0, COUNT, v);
        chk("mid_count", v, 199);
        tick_in[0] = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_chout", 32'(ch_out), 0);
        chk("rst_irq_now", 32'(irq), 0);
        rd(0, COUNT, v);
        chk("rst_count0", v, 0);
        rd(0, CTRL, v);
        chk("rst_ctrl0b", v, 0);
        rd(2, STATUS, v);
        chk("rst_status2", v, 0);
        step(); step();
        rst_n = 1'b1;
        repeat (4) step();
        rd(0, COUNT, v);
        chk("rst_no_resume", v, 0);
        tick_in[0] = 1'b0;
        repeat (3) step();
        wr(0, CTRL, 1);
        chk("resume_chout", 32'(ch_out[0]), 1);
        tick(0);
        rd(0, STATUS, v);
        chk("resume_load0_done", v, 1);
        chk("resume_chout_off", 32'(ch_out[0]), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
